// File: rtl/fetch_pkg.sv
// Shared fetch-side types: default widths, the {pc, ins} entry held by the
// IF/ID queue, and the queue occupancy states.
package fetch_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int INS_W_DEF = 32;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] ins;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } occState_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop side, flush and
// occupancy status. The master is the pipeline around the queue, the slave is the queue.
interface if_id_queue_if #(
  parameter int PC_W  = 8,
  parameter int INS_W = 32,
  parameter int DEPTH = 2
);

  logic                       in_valid;
  logic                       in_ready;
  logic [PC_W-1:0]            in_pc;
  logic [INS_W-1:0]           in_ins;
  logic                       out_valid;
  logic                       out_ready;
  logic [PC_W-1:0]            out_pc;
  logic [INS_W-1:0]           out_ins;
  logic [PC_W-1:0]            out_pc_plus1;
  logic                       flush;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       empty;

  modport master (
    output in_valid, in_pc, in_ins, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_ins, out_pc_plus1, count, full, empty
  );

  modport slave (
    input  in_valid, in_pc, in_ins, out_ready, flush,
    output in_ready, out_valid, out_pc, out_ins, out_pc_plus1, count, full, empty
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH fetch entries, one synchronous
// write port, one asynchronous read port, and no reset on the array.
module if_id_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [PTR_W-1:0] wrAddr,
  input  fetch_entry_t     wrData,
  input  logic [PTR_W-1:0] rdAddr,
  output fetch_entry_t     rdData
);

  fetch_entry_t storage [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      storage[wrAddr] <= wrData;
    end
  end

  assign rdData = storage[rdAddr];

endmodule

// File: rtl/if_id_queue.sv
// Elastic {pc, ins} buffer between fetch and decode, with flush on redirect.
// Defining IF_ID_QUEUE_BYPASS_EN lets an entry reach decode the same cycle when empty.
module if_id_queue
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int INS_W = INS_W_DEF,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  occState_e          state, stateNext;
  logic [CNT_W-1:0]   countReg, countNext;
  logic [PTR_W-1:0]   wrPtr, rdPtr;
  logic               empty, full, bypass, consumed, push, pop, headValid;
  fetch_entry_t       inEntry, rdEntry, headEntry;
  logic [PC_W-1:0]    headPc;

  assign empty = (state == ST_EMPTY);
  assign full  = (state == ST_FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = empty & q.in_valid & ~q.flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle is never written.
  assign consumed = bypass & q.out_ready;
  assign push     = q.in_valid & ~full & ~q.flush & ~consumed;
  assign pop      = ~empty & q.out_ready & ~q.flush;

  assign inEntry.pc  = PC_W_DEF'(q.in_pc);
  assign inEntry.ins = INS_W_DEF'(q.in_ins);

  if_id_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) mem (
    .clk    (clk),
    .wrEn   (push),
    .wrAddr (wrPtr),
    .wrData (inEntry),
    .rdAddr (rdPtr),
    .rdData (rdEntry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      countReg <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
    end else begin
      state    <= stateNext;
      countReg <= countNext;
      if (q.flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  // Occupancy follows count; flush wins over any push or pop.
  always_comb begin
    stateNext = state;
    countNext = countReg;
    if (q.flush) begin
      stateNext = ST_EMPTY;
      countNext = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            stateNext = ST_PARTIAL;
            countNext = CNT_W'(1);
          end
        end
        ST_PARTIAL: begin
          if (push && !pop) begin
            countNext = countReg + 1'b1;
            if (countReg == CNT_W'(DEPTH-1)) stateNext = ST_FULL;
          end else if (pop && !push) begin
            countNext = countReg - 1'b1;
            if (countReg == CNT_W'(1)) stateNext = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            stateNext = ST_PARTIAL;
            countNext = countReg - 1'b1;
          end
        end
        default: begin
          stateNext = ST_EMPTY;
          countNext = '0;
        end
      endcase
    end
  end

  assign headValid = ~empty | bypass;
  assign headEntry = bypass ? inEntry : rdEntry;
  assign headPc    = PC_W'(headEntry.pc);

  assign q.in_ready     = ~full;
  assign q.out_valid    = headValid;
  assign q.out_pc       = headValid ? headPc : '0;
  assign q.out_ins      = headValid ? INS_W'(headEntry.ins) : '0;
  assign q.out_pc_plus1 = headValid ? headPc + 1'b1 : '0;
  assign q.count        = countReg;
  assign q.full         = full;
  assign q.empty        = empty;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue at DEPTH=2, PC_W=8, INS_W=32.
// Expected values are hand-derived from the queue's intended behaviour.
module tb_if_id_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  if_id_queue_if #(.PC_W(8), .INS_W(32), .DEPTH(2)) bus ();

  if_id_queue #(.PC_W(8), .INS_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [7:0] pc, input logic [31:0] ins,
                               input logic ready, input logic fl);
    bus.in_valid  = valid;
    bus.in_pc     = pc;
    bus.in_ins    = ins;
    bus.out_ready = ready;
    bus.flush     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_pc", 32'(bus.out_pc), 32'd0);
    checkOutput("rst_out_ins", bus.out_ins, 32'd0);
    checkOutput("rst_out_pc_plus1", 32'(bus.out_pc_plus1), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idle_count", 32'(bus.count), 32'd0);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] single push");
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("push_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("push_out_pc", 32'(bus.out_pc), 32'h10);
    checkOutput("push_out_ins", bus.out_ins, 32'hDEADBEEF);
    checkOutput("push_out_pc_plus1", 32'(bus.out_pc_plus1), 32'h11);
    checkOutput("push_count", 32'(bus.count), 32'd1);
    checkOutput("push_empty", 32'(bus.empty), 32'd0);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain1_count", 32'(bus.count), 32'd0);
    checkOutput("drain1_out_pc", 32'(bus.out_pc), 32'd0);

    $display("[TB] fill past depth");
    applyStimulus(1'b1, 8'h00, 32'h10000000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h01, 32'h10000001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h02, 32'h10000002, 1'b0, 1'b0);
    #1;
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("full_full", 32'(bus.full), 32'd1);
    checkOutput("full_count", 32'(bus.count), 32'd2);
    tick();
    checkOutput("refused_count", 32'(bus.count), 32'd2);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("order0_ins", bus.out_ins, 32'h10000000);
    checkOutput("order0_pc", 32'(bus.out_pc), 32'h00);
    tick();
    checkOutput("order1_pc", 32'(bus.out_pc), 32'h01);
    checkOutput("order1_ins", bus.out_ins, 32'h10000001);
    checkOutput("order1_count", 32'(bus.count), 32'd1);
    tick();
    checkOutput("drained_count", 32'(bus.count), 32'd0);
    checkOutput("drained_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] pop while full, then push and pop together");
    applyStimulus(1'b1, 8'h20, 32'h20000020, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h21, 32'h20000021, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 32'h20000022, 1'b1, 1'b0);
    #1;
    checkOutput("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("fullpop_count", 32'(bus.count), 32'd1);
    checkOutput("fullpop_head", 32'(bus.out_pc), 32'h21);
    checkOutput("fullpop_in_ready_after", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("pushpop_count", 32'(bus.count), 32'd1);
    checkOutput("pushpop_head", 32'(bus.out_pc), 32'h22);
    checkOutput("pushpop_ins", bus.out_ins, 32'h20000022);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("pushpop_drained", 32'(bus.count), 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h30, 32'h30000030, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h31, 32'h30000031, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h40, 32'h40000040, 1'b1, 1'b1);
    #1;
    checkOutput("flushcyc_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("flushcyc_head", 32'(bus.out_pc), 32'h30);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_count", 32'(bus.count), 32'd0);
    checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput("flush_dropped_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h50, 32'h50000050, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("postflush_head", 32'(bus.out_pc), 32'h50);
    checkOutput("postflush_count", 32'(bus.count), 32'd1);
    tick();

    $display("[TB] pc wrap");
    applyStimulus(1'b1, 8'hFF, 32'hFFFF0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("wrap_out_pc", 32'(bus.out_pc), 32'hFF);
    checkOutput("wrap_out_pc_plus1", 32'(bus.out_pc_plus1), 32'h00);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'h60, 32'h60000060, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    checkOutput("pre_reset_count", 32'(bus.count), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midrst_count", 32'(bus.count), 32'd0);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("after_rst_empty", 32'(bus.empty), 32'd1);

`ifdef IF_ID_QUEUE_BYPASS_EN
    $display("[TB] bypass");
    applyStimulus(1'b1, 8'h05, 32'h05050505, 1'b1, 1'b0);
    #1;
    checkOutput("bypass_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bypass_out_pc", 32'(bus.out_pc), 32'h05);
    checkOutput("bypass_out_pc_plus1", 32'(bus.out_pc_plus1), 32'h06);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("bypass_count", 32'(bus.count), 32'd0);
    checkOutput("bypass_after_valid", 32'(bus.out_valid), 32'd0);
`else
    $display("[TB] no same-cycle path");
    applyStimulus(1'b1, 8'h05, 32'h05050505, 1'b1, 1'b0);
    #1;
    checkOutput("nobypass_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("nobypass_out_pc", 32'(bus.out_pc), 32'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("nobypass_count", 32'(bus.count), 32'd1);
    checkOutput("nobypass_head", 32'(bus.out_pc), 32'h05);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Small elastic buffer between the instruction-fetch stage and decode. Captures each fetched {pc, ins} pair, holds up to DEPTH entries, and presents them in order to decode over a valid/ready handshake. Fetch keeps issuing while decode stalls. A flush input discards all buffered, wrong-path instructions on a taken branch or jump.

## Interface
- PC_W, 8, program-counter width; instruction memory is 2**PC_W words
- INS_W, 32, instruction width
- DEPTH, 2, number of entries; power of two, >= 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue accepts; equals !full
- in_pc  input  PC_W  address of the fetched instruction
- in_ins  input  INS_W  fetched instruction word
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode consumes the head entry
- out_pc  output  PC_W  head PC; 0 when out_valid=0
- out_ins  output  INS_W  head instruction; 0 when out_valid=0
- out_pc_plus1  output  PC_W  out_pc + 1 mod 2**PC_W; 0 when out_valid=0
- flush  input  1  discard all entries and any input this cycle
- count  output  $clog2(DEPTH+1)  entries held
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- push = in_valid & in_ready & !flush: writes {in_pc, in_ins} at wr_ptr and advances wr_ptr.
- pop = out_valid & out_ready & !flush: advances rd_ptr.
- Simultaneous push and pop leave count unchanged and advance both pointers.
- in_ready depends only on full, never on out_ready. A full queue refuses input even in a cycle where it pops.
- flush has priority over push and pop. On the next edge: count=0, wr_ptr=rd_ptr=0, and the input offered in the flush cycle is dropped.
- Occupancy state is derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on push without pop when count = DEPTH-1.
  - FULL to PARTIAL on pop.
  - PARTIAL to EMPTY on pop without push when count = 1.
  - Any state to EMPTY on flush.
- out_pc_plus1 is truncated to PC_W bits, so 255 wraps to 0 when PC_W=8.

## Timing
- Reset (asynchronous, immediate): count=0, pointers=0, out_valid=0, in_ready=1, empty=1, full=0, and out_pc, out_ins, out_pc_plus1 all 0. Storage contents are don't-care.
- Without bypass, latency from push to out_valid is 1 cycle.
- out_valid depends only on registered state, except on the bypass path.
- In the flush cycle, out_valid still reflects the pre-flush state. Decode must ignore the head while flush=1, and the pop is not counted.
- Reset asserted mid-operation clears all state immediately. No entry survives.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined:
  - When empty and in_valid=1 with flush=0, the input passes combinationally to out_valid, out_pc, out_ins and out_pc_plus1 in the same cycle.
  - If out_ready=1 in that cycle, the entry is consumed and not stored; count stays 0.
  - If out_ready=0, the entry is stored normally.
  - While flush=1, out_valid is forced to 0 on the bypass path.
- IF_ID_QUEUE_BYPASS_EN undefined: there is no combinational path from the in_* ports to the out_* ports, and latency is always 1 cycle.

## Structure
- Shared package fetch_pkg holds:
  - PC_W_DEF=8 and INS_W_DEF=32
  - typedef fetch_entry_t as a packed struct of pc [PC_W] and ins [INS_W]
- One sub-module, if_id_queue_mem, holds the storage: DEPTH x fetch_entry_t, one synchronous write port, one asynchronous read port, no reset on the array.
- Pointer, count, flush and bypass logic live in if_id_queue.

## Test plan
- Reset, then idle: count=0, empty=1, in_ready=1, out_valid=0, out_pc=0, out_ins=0.
- Push pc=0x10 ins=0xDEADBEEF with out_ready=0: out_valid=1 the next cycle, out_pc=0x10, out_pc_plus1=0x11, count=1.
- Three pushes with out_ready=0 at DEPTH=2: the third is refused (in_ready=0, full=1, count=2). Then out_ready=1 drains entries in order pc 0x00, 0x01.
- Queue full; in the same cycle in_valid=1 and out_ready=1: pop occurs, push refused, count goes 2 to 1. Next cycle in_ready=1.
- Two entries held, flush=1 with in_valid=1 pc=0x40: the next cycle count=0, out_valid=0, and 0x40 never appears at the output.
- Head pc=0xFF: out_pc_plus1=0x00. With IF_ID_QUEUE_BYPASS_EN defined, empty, in_valid=1 pc=0x05 and out_ready=1: out_valid=1 and out_pc=0x05 in the same cycle, count stays 0.
